// File: rtl/pipe_chain_pkg.sv
// rtl/pipe_chain_pkg.sv - stage indices, stage index type and payload field offsets for the stage chain
package pipe_chain_pkg;

   localparam int PIPE_STAGES_DEFAULT = 5;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   // Wide enough to name any stage of the largest legal chain (8 stages).
   localparam int STG_IDX_W = 3;
   typedef logic [STG_IDX_W-1:0] stage_idx_t;

   // Payload layout shared with the stage datapaths hanging off stage_bus.
   localparam int PL_PC_LSB   = 0;
   localparam int PL_PC_W     = 32;
   localparam int PL_INST_LSB = 32;
   localparam int PL_INST_W   = 32;

   function automatic stage_idx_t clamp_stage(input int idx, input int stages);
      if (idx >= stages) return stage_idx_t'(stages - 1);
      return stage_idx_t'(idx);
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one valid/bus pipeline register with allowin/go handshake and kill
module pipe_stage_reg
   import pipe_chain_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             kill,
   input  logic             in_go,
   input  logic             in_drop,
   input  logic [WIDTH-1:0] in_bus,
   input  logic             ready_go,
   input  logic             next_allowin,
   output logic             valid,
   output logic [WIDTH-1:0] bus,
   output logic             allowin,
   output logic             go
);

   assign allowin = !valid || (ready_go && next_allowin);
   assign go      = valid && ready_go;

   // The bus follows every transfer even when the slot is killed or the item dropped;
   // only the valid bit decides whether the payload means anything.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         bus   <= '0;
      end else begin
         if (kill)
            valid <= 1'b0;
         else if (allowin)
            valid <= in_go && !in_drop;
         if (in_go && allowin)
            bus <= in_bus;
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised valid/allowin stage chain with flush; PIPE_STAGE_CHAIN_PERF_EN adds perf counters
module pipe_stage_chain
   import pipe_chain_pkg::*;
#(
   parameter int STAGES = PIPE_STAGES_DEFAULT,
   parameter int WIDTH  = 64,
   parameter int SW     = $clog2(STAGES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_allowin,
   input  logic [WIDTH-1:0]           in_bus,
   input  logic [STAGES-1:0]          stage_ready_go,
   input  logic                       flush_valid,
   input  logic [SW-1:0]              flush_stage,
   output logic                       out_valid,
   input  logic                       out_allowin,
   output logic [WIDTH-1:0]           out_bus,
   output logic [STAGES-1:0]          stage_valid,
   output logic [STAGES*WIDTH-1:0]    stage_bus,
   output logic [$clog2(STAGES+1)-1:0] occupancy,
   output logic [31:0]                perf_stall_cnt,
   output logic [31:0]                perf_retire_cnt
);

   localparam int OW = $clog2(STAGES + 1);

   // Index 0 of each array is the upstream side; index i+1 is the output of stage i.
   logic             allowin_a [STAGES+1];
   logic             go_a      [STAGES+1];
   logic [WIDTH-1:0] bus_a     [STAGES+1];
   stage_idx_t       flush_eff;

   assign flush_eff = clamp_stage({{(32-SW){1'b0}}, flush_stage}, STAGES);

   assign in_allowin          = allowin_a[0] && !reset;
   assign go_a[0]             = in_valid && in_allowin;
   assign bus_a[0]            = in_bus;
   assign allowin_a[STAGES]   = out_allowin;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic kill;
      logic drop;

      assign kill = flush_valid && (stage_idx_t'(i) < flush_eff);
      // An item entering during a flush is consumed but never becomes valid.
      assign drop = (i == 0) ? flush_valid : 1'b0;

      pipe_stage_reg #(
         .WIDTH(WIDTH)
      ) u_reg (
         .clk         (clk),
         .reset       (reset),
         .kill        (kill),
         .in_go       (go_a[i]),
         .in_drop     (drop),
         .in_bus      (bus_a[i]),
         .ready_go    (stage_ready_go[i]),
         .next_allowin(allowin_a[i+1]),
         .valid       (stage_valid[i]),
         .bus         (bus_a[i+1]),
         .allowin     (allowin_a[i]),
         .go          (go_a[i+1])
      );

      assign stage_bus[i*WIDTH +: WIDTH] = bus_a[i+1];
   end

   assign out_valid = stage_valid[STAGES-1] && stage_ready_go[STAGES-1];
   assign out_bus   = bus_a[STAGES];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++)
         occupancy = occupancy + OW'(stage_valid[i]);
   end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] retire_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         retire_q <= '0;
      end else begin
         if (stage_valid[STAGES-1] && !(stage_ready_go[STAGES-1] && out_allowin))
            stall_q <= stall_q + 32'd1;
         if (out_valid && out_allowin)
            retire_q <= retire_q + 32'd1;
      end
   end

   assign perf_stall_cnt  = stall_q;
   assign perf_retire_cnt = retire_q;
`else
   assign perf_stall_cnt  = '0;
   assign perf_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain with an item-movement reference model
module tb_pipe_stage_chain;

   localparam int S = 5;
   localparam int W = 8;

   logic                clk;
   logic                reset;
   logic                in_valid;
   logic                in_allowin;
   logic [W-1:0]        in_bus;
   logic [S-1:0]        stage_ready_go;
   logic                flush_valid;
   logic [2:0]          flush_stage;
   logic                out_valid;
   logic                out_allowin;
   logic [W-1:0]        out_bus;
   logic [S-1:0]        stage_valid;
   logic [S*W-1:0]      stage_bus;
   logic [2:0]          occupancy;
   logic [31:0]         perf_stall_cnt;
   logic [31:0]         perf_retire_cnt;

   pipe_stage_chain #(
      .STAGES(S),
      .WIDTH (W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_allowin     (in_allowin),
      .in_bus         (in_bus),
      .stage_ready_go (stage_ready_go),
      .flush_valid    (flush_valid),
      .flush_stage    (flush_stage),
      .out_valid      (out_valid),
      .out_allowin    (out_allowin),
      .out_bus        (out_bus),
      .stage_valid    (stage_valid),
      .stage_bus      (stage_bus),
      .occupancy      (occupancy),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_retire_cnt(perf_retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: which slots hold an item and what each slot's payload register holds.
   logic [S-1:0] mv;
   logic [W-1:0] md [S];
   logic [W-1:0] exp_q [$];
   logic [31:0]  m_stall;
   logic [31:0]  m_retire;
   int           checks;
   int           errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle, check registered state and handshakes, then move items as the rules say.
   task automatic step(input logic iv, input logic [W-1:0] ib, input logic [S-1:0] rg,
                       input logic fv, input logic [2:0] fs, input logic oa, input logic rst);
      logic [S-1:0]   adv;
      logic [S-1:0]   room;
      logic [S-1:0]   nv;
      logic [W-1:0]   nd [S];
      logic [S*W-1:0] flat;
      logic           nxt;
      logic           acc;
      int             fe;
      int             kills;
      in_valid       = iv;
      in_bus         = ib;
      stage_ready_go = rg;
      flush_valid    = fv;
      flush_stage    = fs;
      out_allowin    = oa;
      reset          = rst;
      #1;
      nxt = oa;
      for (int i = S - 1; i >= 0; i--) begin
         adv[i]  = mv[i] && rg[i] && nxt;
         room[i] = !mv[i] || adv[i];
         nxt     = room[i];
      end
      acc = iv && room[0] && !rst;
      for (int i = 0; i < S; i++) flat[i*W +: W] = md[i];
      chk("in_allowin", in_allowin, room[0] && !rst);
      chk("out_valid", out_valid, mv[S-1] && rg[S-1]);
      chk("out_bus", out_bus, md[S-1]);
      chk("stage_valid", stage_valid, mv);
      chk("occupancy", occupancy, $countones(mv));
      chk("stage_bus", stage_bus, flat);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      chk("perf_stall", perf_stall_cnt, m_stall);
      chk("perf_retire", perf_retire_cnt, m_retire);
`else
      chk("perf_stall", perf_stall_cnt, 64'd0);
      chk("perf_retire", perf_retire_cnt, 64'd0);
`endif
      if (rst) begin
         mv = '0;
         for (int i = 0; i < S; i++) md[i] = '0;
         exp_q.delete();
         m_stall  = '0;
         m_retire = '0;
      end else begin
         if (mv[S-1] && !(rg[S-1] && oa)) m_stall++;
         if (adv[S-1]) m_retire++;
         nv = mv & ~adv;
         for (int i = 0; i < S; i++) nd[i] = md[i];
         for (int i = 0; i < S - 1; i++)
            if (adv[i]) begin
               nv[i+1] = 1'b1;
               nd[i+1] = md[i];
            end
         if (acc) begin
            nd[0] = ib;
            nv[0] = !fv;
            if (!fv) exp_q.push_back(ib);
         end
         if (fv) begin
            fe    = (int'(fs) >= S) ? S - 1 : int'(fs);
            kills = 0;
            for (int i = 0; i < fe; i++)
               if (nv[i]) begin
                  nv[i] = 1'b0;
                  kills++;
               end
            repeat (kills) void'(exp_q.pop_back());
         end
         mv = nv;
         for (int i = 0; i < S; i++) md[i] = nd[i];
      end
      @(negedge clk);
   endtask

   // Monitor: every retirement must be the oldest surviving accepted item.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid && out_allowin) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL retire_unexpected actual=%0h expected=none", out_bus);
            end else begin
               chk("retire_data", out_bus, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_out;
      checks   = 0;
      errors   = 0;
      mv       = '0;
      m_stall  = '0;
      m_retire = '0;
      for (int i = 0; i < S; i++) md[i] = '0;
      reset          = 1'b1;
      in_valid       = 1'b0;
      in_bus         = '0;
      stage_ready_go = '1;
      flush_valid    = 1'b0;
      flush_stage    = '0;
      out_allowin    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b1);

      // Streaming 0x01..0x0A back to back.
      first_out = -1;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 8'(k + 1), 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
         if (out_valid && first_out < 0) first_out = k + 1;
      end
      chk("latency", first_out - 1, S - 1);
      chk("stream_occ", occupancy, 5);

      // Back-pressure on a full chain.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 8'($urandom), 5'h1f, 1'b0, 3'd0, 1'b0, 1'b0);
         chk("bp_valid", stage_valid, 5'b11111);
         chk("bp_bus", out_bus, 8'h06);
         chk("bp_allowin", in_allowin, 1'b0);
      end
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);

      // Bubble squeeze behind a stalled stage 3.
      step(1'b1, 8'h30, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'h31, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'h32, 5'b10111, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'h33, 5'b10111, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("squeeze_valid", stage_valid, 5'b01111);
      chk("squeeze_hold", stage_bus[3*W +: W], 8'h30);
      for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);

      // Flush from stage 2 with a full chain and an incoming item.
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h10 + k), 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'hAA, 5'h1f, 1'b1, 3'd2, 1'b1, 1'b0);
      chk("flush_valid", stage_valid, 5'b11100);
      chk("flush_occ", occupancy, 3);
      chk("flush_s2", stage_bus[2*W +: W], 8'h13);

      // Reset in the middle of a full chain.
      for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 5'h1f, 1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b1, 8'h55, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b1);
      chk("rst_valid", stage_valid, 5'b00000);
      chk("rst_bus", out_bus, 8'h00);
      step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("rst_allowin", in_allowin, 1'b1);

      // Four stall cycles then six retires.
      step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 5'h1f, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom), 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      chk("perf_stall_total", perf_stall_cnt, 32'd4);
      chk("perf_retire_total", perf_retire_cnt, 32'd6);
`else
      chk("perf_stall_off", perf_stall_cnt, 32'd0);
      chk("perf_retire_off", perf_retire_cnt, 32'd0);
`endif

      // Randomized traffic: stalls, back-pressure, clamped flush indices, occasional reset.
      for (int k = 0; k < 400; k++) begin
         logic [S-1:0] rg;
         for (int b = 0; b < S; b++) rg[b] = ($urandom_range(7) != 0);
         step($urandom_range(3) != 0, 8'($urandom), rg, $urandom_range(15) == 0,
              3'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(99) == 0);
      end

      for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 5'h1f, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of STAGES pipeline registers with a per-stage valid/allowin handshake. Generalises the fixed five-stage IF/ID/EX/MEM/WB wiring into one reusable block.
- Adds behaviour the fixed wiring lacks: per-stage stall (ready_go), a targeted flush of younger stages, and per-stage visibility of valid/bus for hazard and forwarding logic.
- Sits between the fetch front end (upstream) and the register-file writeback sink (downstream). Stage datapaths hang off the exposed stage buses.

Parameters:
- STAGES, 5, number of register stages; legal range 2..8. Stage 0 is the youngest, stage STAGES-1 the oldest.
- WIDTH, 64, payload bus width per stage.
- SW, $clog2(STAGES), width of the flush stage index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an item.
- in_allowin  out  1  chain accepts an item this cycle.
- in_bus  in  WIDTH  upstream payload.
- stage_ready_go  in  STAGES  bit i=1: stage i has finished its work.
- flush_valid  in  1  flush request.
- flush_stage  in  SW  stage F issuing the flush; stages 0..F-1 are killed.
- out_valid  out  1  oldest stage valid and its ready_go is 1.
- out_allowin  in  1  downstream accepts.
- out_bus  out  WIDTH  oldest-stage payload.
- stage_valid  out  STAGES  valid bit of each stage.
- stage_bus  out  STAGES*WIDTH  flattened payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- occupancy  out  $clog2(STAGES+1)  count of valid stages.
- perf_stall_cnt  out  32  performance counter; see Optional Feature.
- perf_retire_cnt  out  32  performance counter; see Optional Feature.

Behaviour:
- Per stage i:
  - allowin_i = !valid_i || (stage_ready_go[i] && allowin_{i+1}), where allowin_STAGES = out_allowin.
  - go_i = valid_i && stage_ready_go[i].
  - go_{-1} = in_valid && in_allowin.
- Register update, in priority order:
  - reset: valid_i <= 0, bus_i <= 0.
  - else if killed_i: valid_i <= 0.
  - else if allowin_i: valid_i <= go_{i-1}.
  - bus_i <= bus_{i-1} (or in_bus for stage 0) only when go_{i-1} && allowin_i; otherwise bus_i holds.
- Kill rule: killed_i = flush_valid && (i < flush_stage).
  - Stage F and all older stages advance normally; the flushing instruction itself is not cancelled.
- Input during flush: in_allowin = allowin_0 and is unaffected by flush. An item presented during a flush cycle is consumed and discarded; stage 0 stays invalid.
- flush_stage = 0 kills only the incoming item. flush_stage >= STAGES is clamped to STAGES-1.
- Reset output values: in_allowin = 0 while reset is high. out_valid, stage_valid, occupancy and out_bus read 0 in the cycle after reset.
- Latency: an item accepted at edge t with all ready_go=1 and out_allowin=1 appears on out_valid in cycle t+STAGES-1. Throughput is one item per cycle.
- Back-pressure:
  - out_allowin=0 with a full chain gives in_allowin=0.
  - Bubbles are squeezed: a stalled older stage does not block younger stages from filling empty slots.
- Simultaneous events:
  - Flush and stall: kill wins over hold for killed stages.
  - Flush and retire: the oldest stage still retires if F = STAGES-1.
- occupancy is the popcount of the registered valid bits. It is registered-state based, not combinational on inputs.

Optional Feature:
- Macro PIPE_STAGE_CHAIN_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle in which valid_{STAGES-1} && !(stage_ready_go[STAGES-1] && out_allowin).
  - perf_retire_cnt increments on each out_valid && out_allowin.
  - Both are 32-bit, wrap modulo 2^32, reset to 0, and are not affected by flush.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package pipe_chain_pkg holds:
  - constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4, PIPE_STAGES_DEFAULT=5;
  - the stage index typedef;
  - the payload field offset constants shared with the stage datapaths.
- Sub-module pipe_stage_reg: one valid/bus register with allowin/go logic and a kill input, instantiated STAGES times in a generate loop.

Test Plan (STAGES=5, WIDTH=8):
- Streaming: all ready_go=1, out_allowin=1, inject 0x01..0x0A back to back → out_bus sequence 0x01..0x0A starting 4 cycles after the first accept, out_valid continuous, occupancy=5 in steady state.
- Back-pressure: fill the chain, hold out_allowin=0 for 3 cycles → in_allowin=0, stage_valid=5'b11111, out_bus holds its value; release → one retire per cycle.
- Bubble squeeze: stage_ready_go[3]=0 for 2 cycles with stages 1..2 empty → younger items advance into the empty slots, and only stages at or below 3 stall once they are occupied.
- Flush: chain full with 0x10..0x14 (0x14 in stage 0), flush_valid=1, flush_stage=2, in_valid=1, in_bus=0xAA → next cycle stages 0,1 invalid, 0xAA discarded, stages 2..4 advanced, occupancy=3.
- Reset mid-stream: assert reset for 1 cycle with a full chain → next cycle all stage_valid=0, out_bus=0, in_allowin=1 once reset is released.
- Perf counters (PIPE_STAGE_CHAIN_PERF_EN defined): 4 stall cycles then 6 retires → perf_stall_cnt=4, perf_retire_cnt=6. Macro undefined → both read 0.
